// File: rtl/disp_pkg.sv
`default_nettype none
// ============================================================================
// Package     : disp_pkg
// Description : Shared definitions for the 7-segment scan controller:
//               default digit count, hex glyph table and FSM state encoding.
//               Glyph bit order is {a,b,c,d,e,f,g}, active high.
// Revision    : 1.0 - initial release
// ============================================================================
package disp_pkg;

    localparam int NUM_DIG_DEF = 6;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_t;

endpackage : disp_pkg
`default_nettype wire

// File: rtl/disp_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface   : disp_scan_ctrl_if
// Description : Bundle between the counter datapath and the display scanner.
//   i_enb        display enable
//   i_dig_data   packed nibbles, nibble k = digit k (digit 0 rightmost)
//   i_dp_mask    per-digit decimal point
//   i_blink_mask per-digit blink enable
//   i_blank_lz   leading-zero blanking enable
//   o_seg_enb    one-hot digit select (all zero = dark)
//   o_seg        segments {a,b,c,d,e,f,g}
//   o_seg_dp     decimal point
//   Modports: master = datapath side, slave = scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface disp_scan_ctrl_if #(
    parameter int NUM_DIG = 6
);
    logic                   i_enb;
    logic [4*NUM_DIG-1:0]   i_dig_data;
    logic [NUM_DIG-1:0]     i_dp_mask;
    logic [NUM_DIG-1:0]     i_blink_mask;
    logic                   i_blank_lz;
    logic [NUM_DIG-1:0]     o_seg_enb;
    logic                   o_seg_dp;
    logic [6:0]             o_seg;

    modport master (
        output i_enb, i_dig_data, i_dp_mask, i_blink_mask, i_blank_lz,
        input  o_seg_enb, o_seg_dp, o_seg
    );

    modport slave (
        input  i_enb, i_dig_data, i_dp_mask, i_blink_mask, i_blank_lz,
        output o_seg_enb, o_seg_dp, o_seg
    );
endinterface : disp_scan_ctrl_if
`default_nettype wire

// File: rtl/seg7_hex_dec.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_dec
// Description : Combinational hex nibble to 7-segment glyph decoder.
//   nib_i  [3:0]  nibble 0..F
//   seg_o  [6:0]  active-high segments {a,b,c,d,e,f,g}
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_dec
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = GLYPH_0;
        case (nib_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = GLYPH_0;
        endcase
    end

endmodule : seg7_hex_dec
`default_nettype wire

// File: rtl/disp_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_ctrl
// Description : Time-multiplexed scan controller for a multi-digit 7-segment
//               display. Each digit slot is SCAN_DIV clocks: BLANK_CYC dark
//               clocks (anti-ghosting) then the digit is driven. Inputs are
//               snapshotted once per frame so a frame never shows torn data.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    disp_scan_ctrl_if.slave (enable, data, masks in; digit drive out)
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int NUM_DIG      = NUM_DIG_DEF,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 83
) (
    input  logic            clk,
    input  logic            rst_n,
    disp_scan_ctrl_if.slave bus
);

    localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W   = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0]  BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIG - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    state_t                 state_q;
    logic [SLOT_W-1:0]      slot_cnt_q;
    logic [DIG_W-1:0]       digit_q;
    logic [BLINK_W-1:0]     blink_cnt_q;
    logic                   blink_phase_q;

    logic [4*NUM_DIG-1:0]   snap_data_q;
    logic [NUM_DIG-1:0]     snap_dp_q;
    logic [NUM_DIG-1:0]     snap_blink_q;
    logic                   snap_lz_q;

    logic [NUM_DIG-1:0]     seg_enb_q;
    logic [6:0]             seg_q;
    logic                   seg_dp_q;

    logic [NUM_DIG-1:0]     seg_enb_d;
    logic [6:0]             seg_d;
    logic                   seg_dp_d;

    logic [3:0]             nib_sel;
    logic                   dp_sel;
    logic                   blink_sel;
    logic                   lz_sel;
    logic [NUM_DIG-1:0]     lz_blank;
    logic                   zero_above;
    logic [6:0]             glyph;

    // A digit is leading-zero blank when it and every higher digit are zero.
    // Scanning from the top keeps a running "all zero so far" flag; digit 0
    // is excluded so a zero value still shows a single "0".
    always_comb begin
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int k = NUM_DIG - 1; k >= 1; k--) begin
            zero_above  = zero_above & (snap_data_q[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_above & snap_lz_q;
        end
    end

    // Per-digit attribute mux driven by the current digit index.
    always_comb begin
        nib_sel   = 4'h0;
        dp_sel    = 1'b0;
        blink_sel = 1'b0;
        lz_sel    = 1'b0;
        for (int k = 0; k < NUM_DIG; k++) begin
            if (digit_q == DIG_W'(k)) begin
                nib_sel   = snap_data_q[4*k +: 4];
                dp_sel    = snap_dp_q[k];
                blink_sel = snap_blink_q[k];
                lz_sel    = lz_blank[k];
            end
        end
    end

    seg7_hex_dec u_dec (
        .nib_i (nib_sel),
        .seg_o (glyph)
    );

    // Blink-dark digits keep their select asserted but show nothing, so the
    // scan timing (and thus brightness of the other digits) is unchanged.
    always_comb begin
        seg_enb_d = '0;
        seg_d     = '0;
        seg_dp_d  = 1'b0;
        if (state_q == ST_DRIVE) begin
            seg_enb_d = NUM_DIG'(1) << digit_q;
            if (!(blink_sel && blink_phase_q)) begin
                seg_d    = lz_sel ? 7'd0 : glyph;
                seg_dp_d = dp_sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            slot_cnt_q    <= '0;
            digit_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            snap_data_q   <= '0;
            snap_dp_q     <= '0;
            snap_blink_q  <= '0;
            snap_lz_q     <= 1'b0;
            seg_enb_q     <= '0;
            seg_q         <= '0;
            seg_dp_q      <= 1'b0;
        end else if (!bus.i_enb) begin
            // Blink counters survive a disable so blinking stays in rhythm.
            state_q    <= ST_IDLE;
            slot_cnt_q <= '0;
            digit_q    <= '0;
            seg_enb_q  <= '0;
            seg_q      <= '0;
            seg_dp_q   <= 1'b0;
        end else begin
            // Outputs reflect the state/slot of the cycle just ending.
            seg_enb_q <= seg_enb_d;
            seg_q     <= seg_d;
            seg_dp_q  <= seg_dp_d;

            case (state_q)
                ST_IDLE: begin
                    state_q      <= ST_BLANK;
                    slot_cnt_q   <= '0;
                    digit_q      <= '0;
                    snap_data_q  <= bus.i_dig_data;
                    snap_dp_q    <= bus.i_dp_mask;
                    snap_blink_q <= bus.i_blink_mask;
                    snap_lz_q    <= bus.i_blank_lz;
                end
                ST_BLANK: begin
                    slot_cnt_q <= slot_cnt_q + 1'b1;
                    if (slot_cnt_q == BLANK_LAST) begin
                        state_q <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (slot_cnt_q == SLOT_LAST) begin
                        slot_cnt_q <= '0;
                        state_q    <= ST_BLANK;
                        if (digit_q == DIG_LAST) begin
                            // Frame wrap: new snapshot and blink bookkeeping.
                            digit_q      <= '0;
                            snap_data_q  <= bus.i_dig_data;
                            snap_dp_q    <= bus.i_dp_mask;
                            snap_blink_q <= bus.i_blink_mask;
                            snap_lz_q    <= bus.i_blank_lz;
                            if (blink_cnt_q == BLINK_LAST) begin
                                blink_cnt_q   <= '0;
                                blink_phase_q <= ~blink_phase_q;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + 1'b1;
                            end
                        end else begin
                            digit_q <= digit_q + 1'b1;
                        end
                    end else begin
                        slot_cnt_q <= slot_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_seg_enb = seg_enb_q;
    assign bus.o_seg     = seg_q;
    assign bus.o_seg_dp  = seg_dp_q;

endmodule : disp_scan_ctrl
`default_nettype wire
